// File: rtl/output_layer_mac.sv
// Output fully-connected layer: streams activations, accumulates ten signed dot
// products in parallel, adds per-class biases and presents saturated scores.
module output_layer_mac #(
    parameter int NUM_SIZE = 26,
    parameter int IN_SIZE  = 12,
    parameter int W_SIZE   = 12,
    parameter int N_INPUTS = 64,
    parameter int ACC_SIZE = 40,
    parameter int CNT_SIZE = 6
) (
    input  logic                     clk,
    input  logic                     GlobalReset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [IN_SIZE-1:0]       InData,
    output logic [CNT_SIZE-1:0]      WeightAddr,
    input  logic [W_SIZE*10-1:0]     Weights,
    input  logic [NUM_SIZE*10-1:0]   Bias,
    output logic [NUM_SIZE*10-1:0]   Num,
    output logic                     NumValid,
    input  logic                     NumReady
);

    localparam int N_CLASSES = 10;
    localparam int PROD_W    = IN_SIZE + W_SIZE;
    localparam int SUM_W     = ((ACC_SIZE > NUM_SIZE) ? ACC_SIZE : NUM_SIZE) + 1;

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_BIAS  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_SIZE-1:0] LAST_IDX = CNT_SIZE'(N_INPUTS - 1);

    localparam logic signed [SUM_W-1:0] NUM_MAX =
        {{(SUM_W - NUM_SIZE + 1){1'b0}}, {(NUM_SIZE - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] NUM_MIN =
        {{(SUM_W - NUM_SIZE + 1){1'b1}}, {(NUM_SIZE - 1){1'b0}}};

    logic [1:0]                       state_q, state_d;
    logic [CNT_SIZE-1:0]              cnt_q, cnt_d;
    logic signed [ACC_SIZE-1:0]       acc_q [N_CLASSES];
    logic signed [ACC_SIZE-1:0]       acc_d [N_CLASSES];
    logic [NUM_SIZE*N_CLASSES-1:0]    num_q, num_d;

    logic signed [PROD_W-1:0]         prod [N_CLASSES];
    logic signed [SUM_W-1:0]          sum  [N_CLASSES];

    // Full-precision products and bias sums, both sign-extended before adding.
    always_comb begin
        for (int k = 0; k < N_CLASSES; k++) begin
            prod[k] = $signed(InData) * $signed(Weights[W_SIZE*k +: W_SIZE]);
            sum[k]  = {{(SUM_W - ACC_SIZE){acc_q[k][ACC_SIZE-1]}}, acc_q[k]}
                    + {{(SUM_W - NUM_SIZE){Bias[NUM_SIZE*k + NUM_SIZE-1]}},
                       Bias[NUM_SIZE*k +: NUM_SIZE]};
        end
    end

    always_comb begin
        // NOTE: every output gets a hold-value default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        num_d   = num_q;

        case (state_q)
            ST_ACCUM: begin
                if (InValid) begin
                    for (int k = 0; k < N_CLASSES; k++) begin
                        acc_d[k] = acc_q[k]
                                 + {{(ACC_SIZE - PROD_W){prod[k][PROD_W-1]}}, prod[k]};
                    end
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_BIAS;
                    end else begin
                        cnt_d = cnt_q + CNT_SIZE'(1);
                    end
                end
            end
            ST_BIAS: begin
                for (int k = 0; k < N_CLASSES; k++) begin
                    if (sum[k] > NUM_MAX) begin
                        num_d[NUM_SIZE*k +: NUM_SIZE] = NUM_MAX[NUM_SIZE-1:0];
                    end else if (sum[k] < NUM_MIN) begin
                        num_d[NUM_SIZE*k +: NUM_SIZE] = NUM_MIN[NUM_SIZE-1:0];
                    end else begin
                        num_d[NUM_SIZE*k +: NUM_SIZE] = sum[k][NUM_SIZE-1:0];
                    end
                    acc_d[k] = '0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (NumReady) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            num_q   <= '0;
            // NOTE: the accumulator bank is plain flops, so it can and must be cleared on reset.
            for (int k = 0; k < N_CLASSES; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            for (int k = 0; k < N_CLASSES; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign InReady    = (state_q == ST_ACCUM);
    assign NumValid   = (state_q == ST_DONE);
    assign WeightAddr = cnt_q;
    assign Num        = num_q;

endmodule

// File: tb/tb_output_layer_mac.sv
// Randomized scoreboard bench for output_layer_mac: a driver pushes model results,
// a monitor pops and compares them on every accepted Num handshake.
module tb_output_layer_mac;

    localparam int NS = 26;
    localparam int IS = 12;
    localparam int WS = 12;
    localparam int NI = 64;
    localparam int AS = 40;
    localparam int CS = 6;
    localparam int NC = 10;

    localparam int K_RAND  = 0;
    localparam int K_BASIC = 1;
    localparam int K_SAT   = 2;
    localparam int K_BOUND = 3;
    localparam int K_KEEP  = 4;

    localparam longint S_MAX = (64'sd1 <<< (NS - 1)) - 1;
    localparam longint S_MIN = -S_MAX - 1;

    logic               clk = 1'b0;
    logic               GlobalReset = 1'b0;
    logic               InValid = 1'b0;
    logic               InReady;
    logic [IS-1:0]      InData = '0;
    logic [CS-1:0]      WeightAddr;
    logic [WS*NC-1:0]   Weights;
    logic [NS*NC-1:0]   Bias;
    logic [NS*NC-1:0]   Num;
    logic               NumValid;
    logic               NumReady = 1'b0;

    always #5 clk = ~clk;

    output_layer_mac #(
        .NUM_SIZE(NS), .IN_SIZE(IS), .W_SIZE(WS),
        .N_INPUTS(NI), .ACC_SIZE(AS), .CNT_SIZE(CS)
    ) dut (
        .clk(clk), .GlobalReset(GlobalReset),
        .InValid(InValid), .InReady(InReady), .InData(InData),
        .WeightAddr(WeightAddr), .Weights(Weights), .Bias(Bias),
        .Num(Num), .NumValid(NumValid), .NumReady(NumReady)
    );

    // Frame contents: weight ROM (read combinationally by WeightAddr), activations, biases.
    logic signed [WS-1:0] rom [NI][NC];
    int                   fdata [NI];
    longint               fbias [NC];

    always_comb begin
        for (int k = 0; k < NC; k++) begin
            Weights[WS*k +: WS] = rom[WeightAddr][k];
            Bias[NS*k +: NS]    = NS'(fbias[k]);
        end
    end

    int                 total = 0;
    int                 bad   = 0;
    logic [NS*NC-1:0]   exp_q [$];
    bit                 hold_ready = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > S_MAX) return S_MAX;
        if (v < S_MIN) return S_MIN;
        return v;
    endfunction

    // Reference: plain dot product plus bias, then clamp.
    function automatic logic [NS*NC-1:0] model();
        logic [NS*NC-1:0] r;
        for (int k = 0; k < NC; k++) begin
            longint s = fbias[k];
            for (int i = 0; i < NI; i++) begin
                s += longint'(fdata[i]) * longint'(rom[i][k]);
            end
            r[NS*k +: NS] = NS'(sat(s));
        end
        return r;
    endfunction

    function automatic int rand_signed(input int half);
        return int'($urandom_range(0, 2 * half - 1)) - half;
    endfunction

    task automatic setup_frame(input int kind);
        int scale;
        scale = ($urandom_range(1) != 0) ? 2048 : 64;
        for (int i = 0; i < NI; i++) begin
            fdata[i] = rand_signed(2048);
            for (int k = 0; k < NC; k++) rom[i][k] = WS'(rand_signed(scale));
        end
        for (int k = 0; k < NC; k++) fbias[k] = longint'(rand_signed(1 << 25));
        case (kind)
            K_BASIC: begin
                for (int i = 0; i < NI; i++) begin
                    fdata[i] = 1;
                    for (int k = 0; k < NC; k++) rom[i][k] = WS'(k);
                end
                for (int k = 0; k < NC; k++) fbias[k] = 100;
            end
            K_SAT: begin
                for (int i = 0; i < NI; i++) begin
                    fdata[i] = 2047;
                    for (int k = 0; k < NC; k++) rom[i][k] = '0;
                    rom[i][3] = 12'sd2047;
                    rom[i][5] = -12'sd2048;
                end
                fbias[3] = 0;
                fbias[5] = 0;
            end
            K_BOUND: begin
                for (int i = 0; i < NI; i++) begin
                    fdata[i] = 0;
                    for (int k = 0; k < NC; k++) rom[i][k] = '0;
                end
                fdata[0]  = 1;
                rom[0][2] = 12'sd1;
                rom[0][3] = -12'sd1;
                rom[0][4] = -12'sd1;
                rom[0][5] = 12'sd1;
                fdata[NI-1]  = 3;
                rom[NI-1][6] = 12'sd5;
                fbias[0] = S_MAX;
                fbias[1] = S_MIN;
                fbias[2] = S_MAX;
                fbias[3] = S_MIN;
                fbias[4] = S_MAX;
                fbias[5] = S_MIN;
                fbias[6] = 0;
            end
            default: ;
        endcase
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!InReady && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!InReady) check("in_ready_timeout", 0, 1);
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_beat(input int d, input int idx);
        InValid = 1'b1;
        InData  = IS'(d);
        wait_ready();
        check($sformatf("weight_addr_beat%0d", idx), longint'(WeightAddr), longint'(idx));
        @(negedge clk);
        InValid = 1'b0;
    endtask

    task automatic run_frame(input int kind, input bit gaps, input bit bp, input int abort_at);
        logic [NS*NC-1:0] e;
        InValid = 1'b0;
        wait_ready();
        if (kind != K_KEEP) setup_frame(kind);
        for (int i = 0; i < NI; i++) begin
            if (i == abort_at) begin
                InValid     = 1'b0;
                GlobalReset = 1'b0;
                @(negedge clk);
                GlobalReset = 1'b1;
                check("abort_num_zero", longint'(Num == '0), 1);
                check("abort_num_valid", longint'(NumValid), 0);
                check("abort_weight_addr", longint'(WeightAddr), 0);
                check("abort_in_ready", longint'(InReady), 1);
                return;
            end
            if (gaps) repeat ($urandom_range(2)) @(negedge clk);
            if (i == NI - 1) begin
                e = model();
                exp_q.push_back(e);
                if (bp) hold_ready = 1'b1;
            end
            send_beat(fdata[i], i);
        end
        check("bias_cycle_num_valid", longint'(NumValid), 0);
        check("bias_cycle_in_ready", longint'(InReady), 0);
        check("bias_cycle_weight_addr", longint'(WeightAddr), 0);
        @(negedge clk);
        check("latency_num_valid", longint'(NumValid), 1);
        if (bp) begin
            for (int c = 0; c < 5; c++) begin
                InValid = 1'b1;
                InData  = IS'(rand_signed(2048));
                check("bp_num_valid", longint'(NumValid), 1);
                check("bp_in_ready", longint'(InReady), 0);
                check("bp_weight_addr", longint'(WeightAddr), 0);
                check("bp_num_stable", longint'(Num == e), 1);
                @(negedge clk);
            end
            InValid    = 1'b0;
            hold_ready = 1'b0;
        end
    endtask

    // Monitor: drives NumReady and scores every completed handshake.
    initial begin
        logic [NS*NC-1:0] e;
        forever begin
            @(negedge clk);
            NumReady = hold_ready ? 1'b0 : ($urandom_range(3) != 0);
            if (NumValid && NumReady && GlobalReset) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    for (int k = 0; k < NC; k++) begin
                        check($sformatf("num%0d", k),
                              longint'($signed(Num[NS*k +: NS])),
                              longint'($signed(e[NS*k +: NS])));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        setup_frame(K_RAND);
        repeat (3) @(negedge clk);
        GlobalReset = 1'b1;
        check("reset_num_zero", longint'(Num == '0), 1);
        check("reset_num_valid", longint'(NumValid), 0);
        check("reset_in_ready", longint'(InReady), 1);
        check("reset_weight_addr", longint'(WeightAddr), 0);

        run_frame(K_BASIC, 1'b0, 1'b0, -1);
        run_frame(K_SAT,   1'b0, 1'b0, -1);
        run_frame(K_BOUND, 1'b1, 1'b0, -1);
        run_frame(K_RAND,  1'b1, 1'b1, -1);
        run_frame(K_RAND,  1'b0, 1'b0, 10);
        run_frame(K_KEEP,  1'b0, 1'b0, -1);
        for (int f = 0; f < 8; f++) begin
            run_frame(K_RAND, 1'($urandom_range(1)), (f == 3), -1);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", longint'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_layer_mac.md
Name: output_layer_mac

Overview:
- Final fully-connected (output) layer of the digit classifier. Sits directly upstream of the 10-way argmax stage.
- Streams hidden-layer activations one per beat and accumulates 10 signed dot products in parallel, one per class.
- Adds per-class biases and saturates each score to NUM_SIZE bits.
- Presents the packed score bus with a valid/ready handshake; the argmax stage consumes the bus directly.

Parameters:
- NUM_SIZE, 26: width of each signed output score. Matches the argmax input element width.
- IN_SIZE, 12: width of each signed activation.
- W_SIZE, 12: width of each signed weight.
- N_INPUTS, 64: activations per frame (dot-product length), ≥ 2.
- ACC_SIZE, 40: width of each internal signed accumulator. Must be ≥ IN_SIZE+W_SIZE+clog2(N_INPUTS)+1.
- CNT_SIZE, 6: width of the input counter. Must be ≥ clog2(N_INPUTS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- GlobalReset  in  1  synchronous, active-low reset.
- InValid  in  1  InData/Weights valid this cycle.
- InReady  out  1  block accepts an activation this cycle.
- InData  in  IN_SIZE  signed activation.
- WeightAddr  out  CNT_SIZE  index of the current activation; drives the combinational-read weight ROM.
- Weights  in  W_SIZE*10  signed weights for WeightAddr. Class k is at [W_SIZE*k +: W_SIZE].
- Bias  in  NUM_SIZE*10  signed biases, static per frame. Class k is at [NUM_SIZE*k +: NUM_SIZE].
- Num  out  NUM_SIZE*10  saturated signed scores. Class k is at [NUM_SIZE*k +: NUM_SIZE].
- NumValid  out  1  Num holds a complete frame result.
- NumReady  in  1  downstream has taken Num.

Behaviour:
- Reset (GlobalReset==0 at the clock edge) sets:
  - state=ACCUM, cnt=0, all acc=0, Num=0, NumValid=0.
  - InReady is 1 in the first cycle after reset.
  - Reset mid-frame or mid-handshake discards partial sums and any pending result.
- State ACCUM:
  - InReady=1, WeightAddr=cnt.
  - On InValid&&InReady, for each k: acc[k] += sext(InData*Weights_k), computed to full IN_SIZE+W_SIZE precision; cnt += 1.
  - If the accepted beat has cnt==N_INPUTS-1, set cnt=0 and go to BIAS.
  - InValid low: no change; gaps of any length are allowed.
- State BIAS (exactly 1 cycle):
  - InReady=0.
  - s_k = acc[k] + sext(Bias_k).
  - Num_k = s_k clamped to [-2^(NUM_SIZE-1), 2^(NUM_SIZE-1)-1].
  - Clear acc. Go to DONE.
- State DONE:
  - NumValid=1, InReady=0, Num stable.
  - InValid in this state is ignored, and no weight read is implied.
  - On NumReady=1: NumValid=0 in the next cycle, go to ACCUM.
  - The next frame's first beat can be accepted in the cycle after the handshake.
- Latency: last beat accepted at edge t → NumValid=1 after edge t+1 (visible in cycle t+2).
- Throughput: N_INPUTS+2 cycles per frame, given continuous InValid and NumReady=1.
- NumReady outside DONE has no effect.
- Num keeps its last value after the handshake; it is only rewritten in BIAS.
- Arithmetic is signed two's complement throughout.
  - Saturation is applied only after the bias add; the accumulators never wrap, guaranteed by the ACC_SIZE rule.
  - Both ends are tie-free: a value exactly at a clamp limit passes through unchanged.
- WeightAddr always equals cnt, including in the BIAS and DONE states (cnt=0 there).

Test Plan:
1. Basic sum: N_INPUTS=4, all InData=1, Weights_k=k, Bias_k=100 → NumValid rises 2 cycles after the 4th beat; Num_k=4k+100 (Num_0=100 … Num_9=136).
2. Saturation: N_INPUTS=64, InData=2047, Weights_3=2047, Bias_3=0 → Num_3=33554431. With Weights_5=-2048 → Num_5=-33554432. Other classes with zero weights → Num=Bias.
3. Backpressure: hold NumReady=0 for 5 cycles in DONE while pulsing InValid=1 with random data → NumValid=1 and InReady=0 throughout; Num unchanged; after NumReady=1, the next frame's result is unaffected by the ignored beats.
4. Input gaps: frame of N_INPUTS=4 with InValid pattern 1,0,0,1,1,0,1 → same Num as the gap-free case; WeightAddr steps 0,1,2,3 only on accepted beats.
5. Reset mid-frame: GlobalReset=0 for 1 cycle after 10 accepted beats → next cycle Num=0, NumValid=0, WeightAddr=0; a fresh full frame gives a result identical to the same frame run with no prior reset.
6. Chained with argmax: weights and biases chosen so Num_7=500 and every other score is ≤ 499 → argmax Index=7 while NumValid=1; a tie Num_2=Num_7=500 → Index=2 (earliest index wins).
